// File: rtl/display_out_unit_pkg.sv
// Shared constants and types for the OUT-instruction display unit:
// segment patterns, FSM state encoding and the double-dabble digit adjust.
package display_out_unit_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    // Width of a counter that indexes n shift steps (at least 1 bit).
    function automatic int bitcnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/display_out_unit_seg7_encode.sv
// Combinational BCD digit to active-low 7-segment pattern (bit 0 = seg a).
// Non-decimal codes render blank.
module seg7_encode
    import display_out_unit_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'h40;
            4'd1: seg = 7'h79;
            4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;
            4'd4: seg = 7'h19;
            4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;
            4'd7: seg = 7'h78;
            4'd8: seg = 7'h00;
            4'd9: seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_out_unit.sv
// OUT-instruction display unit: serial double-dabble conversion of a latched
// register value, then a single registered update of N_DIGITS 7-seg displays.
module display_out_unit
    import display_out_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int N_DIGITS = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  out_valid,
    output logic                  out_ready,
    input  logic [DATA_W-1:0]     out_data,
    input  logic                  signed_mode,
    output logic [7*N_DIGITS-1:0] hex_seg,
    output logic                  done,
    output logic                  overflow,
    output logic [1:0]            state_dbg
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = bitcnt_w(DATA_W);

    // Handshake: a strobe transfers on a rising edge where out_valid and
    // out_ready are both high; out_ready is high exactly while the FSM is idle.
    state_t             state, state_next;
    logic [DATA_W-1:0]  mag;
    logic [BCD_W-1:0]   bcd, bcd_adj;
    logic [CNT_W-1:0]   bitcnt;
    logic               neg, ovf_int, show_ovf, lead;
    logic [6:0]         seg_raw [N_DIGITS];
    logic [7*N_DIGITS-1:0] seg_next;

    assign out_ready = (state == ST_IDLE);
    assign state_dbg = state;

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (out_valid) state_next = ST_SHIFT;
            ST_SHIFT:  if (bitcnt == CNT_W'(DATA_W - 1)) state_next = ST_UPDATE;
            ST_UPDATE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = '0;
        for (int k = 0; k < N_DIGITS; k++)
            bcd_adj[4*k +: 4] = dabble_adj(bcd[4*k +: 4]);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mag      <= '0;
            bcd      <= '0;
            bitcnt   <= '0;
            neg      <= 1'b0;
            ovf_int  <= 1'b0;
            hex_seg  <= '1;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (out_valid) begin
                    // -x of the most-negative value wraps to 2^(DATA_W-1), the true magnitude.
                    mag     <= (signed_mode && out_data[DATA_W-1]) ? -out_data : out_data;
                    neg     <= signed_mode && out_data[DATA_W-1];
                    bcd     <= '0;
                    bitcnt  <= '0;
                    ovf_int <= 1'b0;
                end
                ST_SHIFT: begin
                    {bcd, mag} <= {bcd_adj[BCD_W-2:0], mag, 1'b0};
                    ovf_int    <= ovf_int | bcd_adj[BCD_W-1];
                    bitcnt     <= bitcnt + 1'b1;
                end
                ST_UPDATE: begin
                    hex_seg  <= seg_next;
                    overflow <= show_ovf;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_enc
        seg7_encode u_enc (
            .bcd (bcd[4*g +: 4]),
            .seg (seg_raw[g])
        );
    end

    // Walk from the top digit down; 'lead' stays set until the first nonzero digit.
    always_comb begin
        show_ovf = ovf_int | (neg & (bcd[BCD_W-1 -: 4] != 4'd0));
        lead     = 1'b1;
        seg_next = '1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            if (bcd[4*k +: 4] != 4'd0) lead = 1'b0;
            if (show_ovf)
                seg_next[7*k +: 7] = SEG_MINUS;
            else if (neg && (k == N_DIGITS - 1))
                seg_next[7*k +: 7] = SEG_MINUS;
            else if ((BLANK_LZ != 0) && lead && (k != 0))
                seg_next[7*k +: 7] = SEG_BLANK;
            else
                seg_next[7*k +: 7] = seg_raw[k];
        end
    end

endmodule

// File: tb/tb_display_out_unit.sv
// Directed bench for display_out_unit (DATA_W=32, N_DIGITS=4), with a second
// instance built with BLANK_LZ=0 sharing the same stimulus.
module tb_display_out_unit;

    localparam logic [6:0] D0 = 7'h40, D1 = 7'h79, D2 = 7'h24, D3 = 7'h30, D4 = 7'h19;
    localparam logic [6:0] D5 = 7'h12, D6 = 7'h02, D7 = 7'h78, D9 = 7'h10;
    localparam logic [6:0] BL = 7'h7F, MI = 7'h3F;
    localparam logic [27:0] ALL_MI = {MI, MI, MI, MI};
    localparam logic [27:0] ALL_BL = {BL, BL, BL, BL};

    typedef struct {
        logic [31:0] data;
        logic        sgn;
        logic [27:0] seg;
        logic        ovf;
        logic        nb_chk;
        logic [27:0] seg_nb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, out_valid, signed_mode;
    logic [31:0] out_data;
    logic        out_ready, done, overflow;
    logic [27:0] hex_seg;
    logic [1:0]  state_dbg;
    logic        ready_nb, done_nb, ovf_nb;
    logic [27:0] hex_nb;
    logic [1:0]  state_nb;

    int n_checks = 0;
    int n_fail   = 0;
    logic [27:0] exp_q[$];
    vec_t vecs[15];

    display_out_unit #(.DATA_W(32), .N_DIGITS(4), .BLANK_LZ(1)) dut (
        .CLOCK_50(clk), .reset(reset), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .signed_mode(signed_mode), .hex_seg(hex_seg),
        .done(done), .overflow(overflow), .state_dbg(state_dbg)
    );

    display_out_unit #(.DATA_W(32), .N_DIGITS(4), .BLANK_LZ(0)) dut_nb (
        .CLOCK_50(clk), .reset(reset), .out_valid(out_valid), .out_ready(ready_nb),
        .out_data(out_data), .signed_mode(signed_mode), .hex_seg(hex_nb),
        .done(done_nb), .overflow(ovf_nb), .state_dbg(state_nb)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: called at a negedge; returns at the negedge just after the accept edge
    task automatic start_conv(input logic [31:0] d, input logic s);
        int w = 0;
        while (!out_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_send", 64'(out_ready), 64'd1);
        out_data    = d;
        signed_mode = s;
        out_valid   = 1'b1;
        @(negedge clk);
        out_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int low);
        lat = 0;
        low = 0;
        while (!done && lat < 200) begin
            if (!out_ready) low++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int low, input logic ovf);
        logic [27:0] exp_seg;
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_ready_low"}, 64'(low), 64'd33);
        exp_seg = (exp_q.size() != 0) ? exp_q.pop_front() : 28'hx;
        check({tag, "_hex"}, 64'(hex_seg), 64'(exp_seg));
        check({tag, "_ovf"}, 64'(overflow), 64'(ovf));
        check({tag, "_ready_after"}, 64'(out_ready), 64'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_hold"}, 64'(hex_seg), 64'(exp_seg));
    endtask

    initial begin
        int lat, low, dcnt;

        vecs[0]  = '{32'd1234,       1'b0, {D1, D2, D3, D4}, 1'b0, 1'b0, 28'h0};
        vecs[1]  = '{32'd7,          1'b0, {BL, BL, BL, D7}, 1'b0, 1'b1, {D0, D0, D0, D7}};
        vecs[2]  = '{32'hFFFF_FFFB,  1'b1, {MI, BL, BL, D5}, 1'b0, 1'b1, {MI, D0, D0, D5}};
        vecs[3]  = '{32'd10000,      1'b0, ALL_MI,           1'b1, 1'b1, ALL_MI};
        vecs[4]  = '{32'hFFFF_FC18,  1'b1, ALL_MI,           1'b1, 1'b0, 28'h0};
        vecs[5]  = '{32'd0,          1'b0, {BL, BL, BL, D0}, 1'b0, 1'b1, {D0, D0, D0, D0}};
        vecs[6]  = '{32'd9999,       1'b0, {D9, D9, D9, D9}, 1'b0, 1'b0, 28'h0};
        vecs[7]  = '{32'hFFFF_FC19,  1'b1, {MI, D9, D9, D9}, 1'b0, 1'b0, 28'h0};
        vecs[8]  = '{32'h8000_0000,  1'b1, ALL_MI,           1'b1, 1'b0, 28'h0};
        vecs[9]  = '{32'hFFFF_FFFF,  1'b0, ALL_MI,           1'b1, 1'b0, 28'h0};
        vecs[10] = '{32'd100,        1'b0, {BL, D1, D0, D0}, 1'b0, 1'b1, {D0, D1, D0, D0}};
        vecs[11] = '{32'd42,         1'b1, {BL, BL, D4, D2}, 1'b0, 1'b0, 28'h0};
        vecs[12] = '{32'd1005,       1'b0, {D1, D0, D0, D5}, 1'b0, 1'b0, 28'h0};
        vecs[13] = '{32'hFFFF_FFFF,  1'b1, {MI, BL, BL, D1}, 1'b0, 1'b0, 28'h0};
        vecs[14] = '{32'd10000,      1'b1, ALL_MI,           1'b1, 1'b0, 28'h0};

        // reset
        reset       = 1'b1;
        out_valid   = 1'b0;
        out_data    = '0;
        signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_hex", 64'(hex_seg), 64'(ALL_BL));
        check("reset_ready", 64'(out_ready), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        check("reset_ovf", 64'(overflow), 64'd0);
        check("reset_hex_nb", 64'(hex_nb), 64'(ALL_BL));

        // table-driven vectors
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(vecs[i].seg);
            start_conv(vecs[i].data, vecs[i].sgn);
            wait_done(lat, low);
            if (vecs[i].nb_chk) check($sformatf("v%0d_hex_nb", i), 64'(hex_nb), 64'(vecs[i].seg_nb));
            check_result($sformatf("v%0d", i), lat, low, vecs[i].ovf);
        end

        // strobe during a conversion is ignored
        exp_q.push_back({BL, BL, D4, D2});
        start_conv(32'd42, 1'b0);
        lat = 0;
        low = 0;
        while (!done && lat < 200) begin
            if (lat == 4) begin
                out_valid = 1'b1;
                out_data  = 32'd99;
            end
            if (lat == 30) out_valid = 1'b0;
            if (!out_ready) low++;
            @(negedge clk);
            lat++;
        end
        out_valid = 1'b0;
        check_result("busy_strobe", lat, low, 1'b0);
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || !out_ready) dcnt++;
        end
        check("busy_no_second_conv", 64'(dcnt), 64'd0);

        // reset mid-conversion aborts
        start_conv(32'd55, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_hex", 64'(hex_seg), 64'(ALL_BL));
        check("abort_ready", 64'(out_ready), 64'd1);
        check("abort_ovf", 64'(overflow), 64'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);
        exp_q.push_back({BL, BL, D6, D6});
        start_conv(32'd66, 1'b0);
        wait_done(lat, low);
        check_result("after_abort", lat, low, 1'b0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
